// File: rtl/bp_stream_host_mmio.sv
// bp_stream_host_mmio: host-side endpoint of the 32-bit MMIO stream link.
// Consumes address/data command pairs, decodes the fixed host address map
// (putchar, getchar, finish, status) and returns 64-bit read responses as two
// words, low word first.
// Optional: define BP_STREAM_HOST_CYCLE_CTR_EN to add a 64-bit cycle counter
// that can be read at 32'h0010_4000.
module bp_stream_host_mmio #(
    parameter int          stream_data_width_p = 32,
    parameter logic [31:0] getchar_addr_p      = 32'h0010_0000,
    parameter logic [31:0] putchar_addr_p      = 32'h0010_1000,
    parameter logic [31:0] finish_addr_p       = 32'h0010_2000,
    parameter logic [31:0] status_addr_p       = 32'h0010_3000
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_yumi_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic                           tx_v_o,
    output logic [7:0]                     tx_data_o,
    input  logic                           tx_ready_i,
    input  logic                           rx_v_i,
    input  logic [7:0]                     rx_data_i,
    output logic                           rx_yumi_o,
    output logic                           finish_o,
    output logic [7:0]                     finish_code_o
);

    // The link and address map are defined for 32-bit words only.
    if (stream_data_width_p != 32) begin : g_bad_width
        $error("bp_stream_host_mmio: stream_data_width_p must be 32");
    end

`ifdef BP_STREAM_HOST_CYCLE_CTR_EN
    localparam logic [31:0] CycleAddr = 32'h0010_4000;
    logic [63:0] ctr_q;

    // Free-running cycle counter; wraps naturally at 2^64.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) ctr_q <= '0;
        else            ctr_q <= ctr_q + 64'd1;
    end
`endif

    typedef enum logic [1:0] {e_addr, e_data, e_resp_lo, e_resp_hi} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] lo_q, lo_d, hi_q, hi_d;
    logic        finish_q, finish_d;
    logic [7:0]  code_q, code_d;

    // State and datapath registers; reset drops any partial command.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= e_addr;
            addr_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            finish_q <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            finish_q <= finish_d;
            code_q   <= code_d;
        end
    end

    // Command decode, response capture and handshake outputs.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        finish_d      = finish_q;
        code_d        = code_q;
        stream_yumi_o = 1'b0;
        stream_v_o    = 1'b0;
        stream_data_o = lo_q;
        tx_v_o        = 1'b0;
        tx_data_o     = stream_data_i[7:0];
        rx_yumi_o     = 1'b0;

        unique case (state_q)
            e_addr: begin
                stream_yumi_o = stream_v_i;
                if (stream_v_i) begin
                    addr_d  = stream_data_i;
                    state_d = e_data;
                end
            end
            e_data: begin
                if (addr_q == putchar_addr_p) begin
                    // Data word is held until the UART accepts the byte.
                    tx_v_o        = stream_v_i;
                    stream_yumi_o = stream_v_i & tx_ready_i;
                    if (stream_yumi_o) state_d = e_addr;
                end else if (addr_q == finish_addr_p) begin
                    stream_yumi_o = stream_v_i;
                    if (stream_v_i) begin
                        if (!finish_q) begin
                            finish_d = 1'b1;
                            code_d   = stream_data_i[7:0];
                        end
                        state_d = e_addr;
                    end
                end else if (addr_q == getchar_addr_p) begin
                    stream_yumi_o = stream_v_i;
                    if (stream_v_i) begin
                        rx_yumi_o = rx_v_i;
                        lo_d      = rx_v_i ? {24'b0, rx_data_i} : 32'hFFFF_FFFF;
                        hi_d      = rx_v_i ? 32'h0 : 32'hFFFF_FFFF;
                        state_d   = e_resp_lo;
                    end
                end else if (addr_q == status_addr_p) begin
                    stream_yumi_o = stream_v_i;
                    if (stream_v_i) begin
                        lo_d    = {22'b0, code_q, finish_q, rx_v_i};
                        hi_d    = 32'h0;
                        state_d = e_resp_lo;
                    end
`ifdef BP_STREAM_HOST_CYCLE_CTR_EN
                end else if (addr_q == CycleAddr) begin
                    stream_yumi_o = stream_v_i;
                    if (stream_v_i) begin
                        lo_d    = ctr_q[31:0];
                        hi_d    = ctr_q[63:32];
                        state_d = e_resp_lo;
                    end
`endif
                end else begin
                    // Unknown address: treated as a write and dropped.
                    stream_yumi_o = stream_v_i;
                    if (stream_v_i) state_d = e_addr;
                end
            end
            e_resp_lo: begin
                stream_v_o    = 1'b1;
                stream_data_o = lo_q;
                if (stream_ready_i) state_d = e_resp_hi;
            end
            e_resp_hi: begin
                stream_v_o    = 1'b1;
                stream_data_o = hi_q;
                if (stream_ready_i) state_d = e_addr;
            end
            default: state_d = e_addr;
        endcase

        // Nothing handshakes while reset is held.
        if (!reset_n_i) begin
            stream_yumi_o = 1'b0;
            stream_v_o    = 1'b0;
            tx_v_o        = 1'b0;
            rx_yumi_o     = 1'b0;
        end
    end

    assign finish_o      = finish_q;
    assign finish_code_o = code_q;

endmodule

// File: tb/tb_bp_stream_host_mmio.sv
// Directed bench for bp_stream_host_mmio.
module tb_bp_stream_host_mmio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_v, yumi, rv, rready, tx_v, tx_ready, rx_v, rx_yumi, fin;
    logic [31:0] s_data, rdata;
    logic [7:0]  tx_data, rx_data, code;

    int errors = 0;
    int checks = 0;
    int cycnt  = 0;
    int tx_hs  = 0;
    int rx_pops = 0;
    int acc_cyc = 0;

    bp_stream_host_mmio dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .stream_v_i(s_v), .stream_data_i(s_data), .stream_yumi_o(yumi),
        .stream_v_o(rv), .stream_data_o(rdata), .stream_ready_i(rready),
        .tx_v_o(tx_v), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
        .rx_v_i(rx_v), .rx_data_i(rx_data), .rx_yumi_o(rx_yumi),
        .finish_o(fin), .finish_code_o(code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycnt <= cycnt + 1;

    always @(negedge clk) begin
        if (tx_v && tx_ready) tx_hs++;
        if (rx_yumi) rx_pops++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one command word until consumed; cyc = cycles spent (1 if immediate).
    task automatic send(input logic [31:0] d, output int cyc);
        s_v = 1'b1; s_data = d; cyc = 1;
        #1;
        while (!yumi && cyc < 20) begin tick; cyc++; end
        acc_cyc = cycnt;
        tick;
        s_v = 1'b0; s_data = '0;
    endtask

    // Accept one response word; cyc = cycles waited before it was valid.
    task automatic recv(output logic [31:0] w, output int cyc);
        rready = 1'b1; cyc = 0;
        #1;
        while (!rv && cyc < 20) begin tick; cyc++; end
        w = rdata;
        tick;
        rready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; s_v = 1'b1; s_data = 32'h0010_1000;
        rx_v = 1'b1; rx_data = 8'h11; tx_ready = 1'b1; rready = 1'b1;
        tick; tick;
        checks++; if (yumi !== 1'b0) begin errors++; $display("FAIL reset_yumi got=%b exp=0", yumi); end
        checks++; if (rv !== 1'b0 || tx_v !== 1'b0 || rx_yumi !== 1'b0) begin errors++;
            $display("FAIL reset_valids got rv=%b tx_v=%b rx_yumi=%b exp=0", rv, tx_v, rx_yumi); end
        checks++; if (fin !== 1'b0 || code !== 8'h00) begin errors++;
            $display("FAIL reset_finish got=%b/%h exp=0/00", fin, code); end
        s_v = 1'b0; rx_v = 1'b0; rready = 1'b0; tx_ready = 1'b0;
        reset_n = 1'b1;
        tick;
        tx_hs = 0; rx_pops = 0;
    endtask

    task automatic test_putchar;
        int c;
        tx_ready = 1'b0;
        send(32'h0010_1000, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL put_addr_cycles got=%0d exp=1", c); end
        s_v = 1'b1; s_data = 32'h0000_0041;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) tx_ready = 1'b1;
            #1;
            checks++;
            if (tx_v !== 1'b1 || tx_data !== 8'h41 || yumi !== (i == 3) || rv !== 1'b0) begin
                errors++;
                $display("FAIL put_cycle%0d got tx_v=%b tx_data=%h yumi=%b rv=%b exp 1/41/%0d/0",
                         i, tx_v, tx_data, yumi, rv, (i == 3));
            end
            tick;
        end
        s_v = 1'b0; s_data = '0;
        #1;
        checks++; if (tx_v !== 1'b0 || tx_hs !== 1) begin errors++;
            $display("FAIL put_handshakes got tx_v=%b hs=%0d exp 0/1", tx_v, tx_hs); end
        tx_ready = 1'b0;
    endtask

    task automatic test_getchar_rx;
        int c;
        logic [31:0] w;
        rx_v = 1'b1; rx_data = 8'h5A;
        send(32'h0010_0000, c);
        s_v = 1'b1; s_data = 32'h0;
        #1;
        checks++; if (yumi !== 1'b1 || rx_yumi !== 1'b1) begin errors++;
            $display("FAIL getc_pop got yumi=%b rx_yumi=%b exp 1/1", yumi, rx_yumi); end
        tick;
        s_v = 1'b0; rx_v = 1'b0;
        recv(w, c);
        checks++; if (w !== 32'h0000_005A || c !== 0) begin errors++;
            $display("FAIL getc_lo got=%h wait=%0d exp=0000005a wait=0", w, c); end
        recv(w, c);
        checks++; if (w !== 32'h0 || rx_pops !== 1) begin errors++;
            $display("FAIL getc_hi got=%h pops=%0d exp=00000000 pops=1", w, rx_pops); end
    endtask

    task automatic test_getchar_empty;
        int c;
        logic [31:0] w, w2;
        rx_v = 1'b0;
        send(32'h0010_0000, c);
        send(32'h0, c);
        recv(w, c);
        recv(w2, c);
        checks++; if (w !== 32'hFFFF_FFFF || w2 !== 32'hFFFF_FFFF || rx_pops !== 1) begin errors++;
            $display("FAIL getc_empty got=%h_%h pops=%0d exp=ffffffff_ffffffff pops=1", w2, w, rx_pops); end
    endtask

    task automatic test_finish_status;
        int c;
        logic [31:0] w, w2;
        send(32'h0010_2000, c);
        send(32'h0000_0007, c);
        checks++; if (fin !== 1'b1 || code !== 8'h07) begin errors++;
            $display("FAIL finish_first got=%b/%h exp=1/07", fin, code); end
        send(32'h0010_2000, c);
        send(32'h0000_0009, c);
        checks++; if (fin !== 1'b1 || code !== 8'h07) begin errors++;
            $display("FAIL finish_sticky got=%b/%h exp=1/07", fin, code); end
        rx_v = 1'b0;
        send(32'h0010_3000, c);
        send(32'h0, c);
        recv(w, c);
        recv(w2, c);
        // {22'b0, code=07, finish=1, rx_v=0}
        checks++; if (w !== 32'h0000_001E || w2 !== 32'h0) begin errors++;
            $display("FAIL status got lo=%h hi=%h exp lo=0000001e hi=00000000", w, w2); end
    endtask

    task automatic test_backpressure_reset;
        int c;
        rx_v = 1'b0; rready = 1'b0;
        send(32'h0010_0000, c);
        send(32'h0, c);
        s_v = 1'b1; s_data = 32'h0010_1000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rv !== 1'b1 || rdata !== 32'hFFFF_FFFF || yumi !== 1'b0) begin errors++;
                $display("FAIL bp_hold%0d got rv=%b data=%h yumi=%b exp 1/ffffffff/0", i, rv, rdata, yumi); end
            tick;
        end
        reset_n = 1'b0;
        #1;
        checks++; if (rv !== 1'b0 || yumi !== 1'b0) begin errors++;
            $display("FAIL bp_reset_outs got rv=%b yumi=%b exp 0/0", rv, yumi); end
        tick;
        reset_n = 1'b1;
        tx_ready = 1'b1;
        #1;
        checks++; if (fin !== 1'b0 || rv !== 1'b0 || yumi !== 1'b1) begin errors++;
            $display("FAIL post_reset got fin=%b rv=%b yumi=%b exp 0/0/1", fin, rv, yumi); end
        tick;
        s_data = 32'h0000_0042;
        #1;
        checks++; if (tx_v !== 1'b1 || tx_data !== 8'h42 || yumi !== 1'b1) begin errors++;
            $display("FAIL post_reset_addr got tx_v=%b tx_data=%h yumi=%b exp 1/42/1", tx_v, tx_data, yumi); end
        tick;
        s_v = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_unknown;
        int c1, c2, hs0;
        hs0 = tx_hs;
        tx_ready = 1'b1;
        send(32'h8000_0000, c1);
        send(32'hDEAD_BEEF, c2);
        checks++; if (c1 !== 1 || c2 !== 1) begin errors++;
            $display("FAIL unk_cycles got=%0d/%0d exp=1/1", c1, c2); end
        // one bit off the putchar address must not alias
        send(32'h0010_1001, c1);
        send(32'h0000_0055, c2);
`ifndef BP_STREAM_HOST_CYCLE_CTR_EN
        send(32'h0010_4000, c1);
        send(32'h0, c2);
`endif
        for (int i = 0; i < 3; i++) begin
            checks++; if (rv !== 1'b0 || tx_hs !== hs0) begin errors++;
                $display("FAIL unk_quiet%0d got rv=%b hs=%0d exp 0/%0d", i, rv, tx_hs, hs0); end
            tick;
        end
        tx_ready = 1'b0;
    endtask

`ifdef BP_STREAM_HOST_CYCLE_CTR_EN
    task automatic test_cycle_ctr;
        int c, ca, cb;
        logic [31:0] a_lo, a_hi, b_lo, b_hi;
        send(32'h0010_4000, c);
        send(32'h0, c);
        ca = acc_cyc;
        recv(a_lo, c);
        recv(a_hi, c);
        send(32'h0010_4000, c);
        // pad so the second data word is consumed exactly 10 cycles later
        while (cycnt < ca + 10) tick;
        send(32'h0, c);
        cb = acc_cyc;
        recv(b_lo, c);
        recv(b_hi, c);
        checks++; if ({b_hi, b_lo} - {a_hi, a_lo} !== 64'(cb - ca) || cb - ca !== 10) begin errors++;
            $display("FAIL ctr_delta got=%0d exp=%0d", {b_hi, b_lo} - {a_hi, a_lo}, cb - ca); end
    endtask
`endif

    initial begin
        reset_n = 1'b0; s_v = 1'b0; s_data = '0; rready = 1'b0;
        tx_ready = 1'b0; rx_v = 1'b0; rx_data = '0;
        test_reset;
        test_putchar;
        test_getchar_rx;
        test_getchar_empty;
        test_finish_status;
        test_backpressure_reset;
        test_unknown;
`ifdef BP_STREAM_HOST_CYCLE_CTR_EN
        test_cycle_ctr;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
